// File: rtl/fei4_rx_pkg.sv
// Shared constants and record classification for the FE-I4 receive filter.
// Record codes, column limit and the identifier field live here.
package fei4_rx_pkg;

  localparam logic [7:0] REC_DH = 8'hE9;
  localparam logic [7:0] REC_AR = 8'hEA;
  localparam logic [7:0] REC_VR = 8'hEC;
  localparam logic [7:0] REC_SR = 8'hEF;

  localparam logic [6:0] MAX_COLUMN = 7'd80;

  localparam int ID_MSB = 31;
  localparam int ID_LSB = 24;

  localparam int CNT_DH  = 0;
  localparam int CNT_DR  = 1;
  localparam int CNT_SR  = 2;
  localparam int CNT_ERR = 3;
  localparam int NUM_CNT = 4;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_IDERR,
    CLS_DH,
    CLS_ARVR,
    CLS_SR,
    CLS_BADCOL,
    CLS_DR
  } rec_cls_e;

  function automatic rec_cls_e classify(
    input logic [31:0] w,
    input logic [7:0]  id
  );
    rec_cls_e   cls;
    logic [7:0] t;
    logic [6:0] col;
    t   = w[23:16];
    col = w[23:17];
    if (w[ID_MSB:ID_LSB] != id) begin
      cls = CLS_IDERR;
    end else begin
      case (t)
        REC_DH:         cls = CLS_DH;
        REC_AR, REC_VR: cls = CLS_ARVR;
        REC_SR:         cls = CLS_SR;
        default: begin
          if (col == 7'd0 || col > MAX_COLUMN)
            cls = CLS_BADCOL;
          else
            cls = CLS_DR;
        end
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/rx_filter_sync_fifo.sv
// Single-clock FIFO with occupancy output; head word is
// presented combinationally (first-word fall-through).
module rx_filter_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [AW:0]      o_occ
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_occ;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_occ == '0);
  assign o_occ   = r_occ;
  assign o_rdata = r_mem[r_rptr];
  assign w_rd    = i_rd & ~o_empty;
  assign w_wr    = i_wr & (r_occ != L_FULL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_rd)
        r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_rd)
        r_occ <= r_occ + (AW+1)'(1);
      else if (w_rd && !w_wr)
        r_occ <= r_occ - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fei4_rx_record_filter.sv
// Pops FE-I4 receiver words, classifies and counts records,
// and forwards the accepted ones through a small output buffer.
module fei4_rx_record_filter
  import fei4_rx_pkg::*;
#(
  parameter logic [7:0] DATA_IDENTIFIER = 8'h00,
  parameter int         OUT_DEPTH       = 4,
  parameter int         CNT_WIDTH       = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic                 ENABLE,
  input  logic                 DROP_SR,
  input  logic                 CNT_CLEAR,
  input  logic                 RX_FIFO_EMPTY,
  input  logic [31:0]          RX_FIFO_DATA,
  output logic                 RX_FIFO_READ,
  output logic                 OUT_VALID,
  output logic [31:0]          OUT_DATA,
  input  logic                 OUT_READY,
  output logic [CNT_WIDTH-1:0] DH_CNT,
  output logic [CNT_WIDTH-1:0] DR_CNT,
  output logic [CNT_WIDTH-1:0] SR_CNT,
  output logic [CNT_WIDTH-1:0] ERR_CNT
);

  localparam int          AW     = $clog2(OUT_DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(OUT_DEPTH);

  logic                 r_s1_valid;
  logic [31:0]          r_s1_data;
  logic                 r_hdr_seen;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_CNT];
  rec_cls_e             w_cls;
  logic [NUM_CNT-1:0]   w_inc;
  logic                 w_wr;
  logic                 w_empty;
  logic [AW:0]          w_occ;
  logic [AW:0]          w_need;

  // Credit counts the word in stage 1 even if it will be dropped.
  assign w_need = w_occ + (AW+1)'(r_s1_valid);
  assign RX_FIFO_READ = BUS_RST_N & ENABLE & ~RX_FIFO_EMPTY
                      & (w_need < L_FULL);

  always_comb begin
    w_cls = CLS_NONE;
    if (r_s1_valid)
      w_cls = classify(r_s1_data, DATA_IDENTIFIER);
    w_inc = '0;
    w_wr  = 1'b0;
    unique case (w_cls)
      CLS_IDERR, CLS_BADCOL: w_inc[CNT_ERR] = 1'b1;
      CLS_DH: begin
        w_inc[CNT_DH] = 1'b1;
        w_wr          = 1'b1;
      end
      CLS_ARVR: w_wr = 1'b1;
      CLS_SR: begin
        w_inc[CNT_SR] = 1'b1;
        w_wr          = ~DROP_SR;
      end
      CLS_DR: begin
        w_inc[CNT_DR]  = 1'b1;
        w_inc[CNT_ERR] = ~r_hdr_seen;
        w_wr           = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= RX_FIFO_READ;
      if (RX_FIFO_READ)
        r_s1_data <= RX_FIFO_DATA;
    end
  end

  // Clearing wins over a DH in the same cycle.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)
      r_hdr_seen <= 1'b0;
    else if (CNT_CLEAR || !ENABLE)
      r_hdr_seen <= 1'b0;
    else if (w_inc[CNT_DH])
      r_hdr_seen <= 1'b1;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      for (int i = 0; i < NUM_CNT; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (CNT_CLEAR)
          r_cnt[i] <= '0;
        else if (w_inc[i] && r_cnt[i] != '1)
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign DH_CNT  = r_cnt[CNT_DH];
  assign DR_CNT  = r_cnt[CNT_DR];
  assign SR_CNT  = r_cnt[CNT_SR];
  assign ERR_CNT = r_cnt[CNT_ERR];

  rx_filter_sync_fifo #(
    .WIDTH (32),
    .DEPTH (OUT_DEPTH)
  ) u_obuf (
    .i_clk   (BUS_CLK),
    .i_rst_n (BUS_RST_N),
    .i_wr    (w_wr),
    .i_wdata (r_s1_data),
    .i_rd    (OUT_READY),
    .o_rdata (OUT_DATA),
    .o_empty (w_empty),
    .o_occ   (w_occ)
  );

  assign OUT_VALID = ~w_empty;

endmodule

// File: tb/tb_fei4_rx_record_filter.sv
// Scoreboard bench for fei4_rx_record_filter: a source queue feeds
// the DUT, a record-rule model predicts outputs and counters.
module tb_fei4_rx_record_filter;

  localparam int         DEPTH = 4;
  localparam logic [7:0] ID    = 8'h01;

  logic        BUS_CLK       = 1'b0;
  logic        BUS_RST_N     = 1'b0;
  logic        ENABLE        = 1'b0;
  logic        DROP_SR       = 1'b0;
  logic        CNT_CLEAR     = 1'b0;
  logic        RX_FIFO_EMPTY = 1'b1;
  logic [31:0] RX_FIFO_DATA  = '0;
  logic        OUT_READY     = 1'b0;
  logic        RX_FIFO_READ;
  logic        OUT_VALID;
  logic [31:0] OUT_DATA;
  logic [15:0] DH_CNT, DR_CNT, SR_CNT, ERR_CNT;

  fei4_rx_record_filter #(
    .DATA_IDENTIFIER (ID),
    .OUT_DEPTH       (DEPTH),
    .CNT_WIDTH       (16)
  ) dut (
    .BUS_CLK       (BUS_CLK),
    .BUS_RST_N     (BUS_RST_N),
    .ENABLE        (ENABLE),
    .DROP_SR       (DROP_SR),
    .CNT_CLEAR     (CNT_CLEAR),
    .RX_FIFO_EMPTY (RX_FIFO_EMPTY),
    .RX_FIFO_DATA  (RX_FIFO_DATA),
    .RX_FIFO_READ  (RX_FIFO_READ),
    .OUT_VALID     (OUT_VALID),
    .OUT_DATA      (OUT_DATA),
    .OUT_READY     (OUT_READY),
    .DH_CNT        (DH_CNT),
    .DR_CNT        (DR_CNT),
    .SR_CNT        (SR_CNT),
    .ERR_CNT       (ERR_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int cyc = 0;
  always @(posedge BUS_CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] src_q [$];
  logic [31:0] exp_q [$];
  int          pop_cyc_q [$];
  int          acc_cyc_q [$];

  int m_dh, m_dr, m_sr, m_err;
  bit m_hdr;
  bit gap_en     = 0;
  bit en_rand    = 0;
  bit clr_on_pop = 0;
  int rdy_pct    = 100;
  int npops      = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_zero();
    m_dh = 0; m_dr = 0; m_sr = 0; m_err = 0; m_hdr = 0;
  endtask

  // Record rules applied to each word in pop order.
  task automatic consume(input logic [31:0] w);
    logic [7:0] t;
    int col;
    t   = w[23:16];
    col = int'(w[23:17]);
    if (w[31:24] != ID) begin
      m_err = sat(m_err);
    end else if (t == 8'hE9) begin
      m_dh = sat(m_dh); m_hdr = 1; exp_q.push_back(w);
    end else if (t == 8'hEA || t == 8'hEC) begin
      exp_q.push_back(w);
    end else if (t == 8'hEF) begin
      m_sr = sat(m_sr);
      if (!DROP_SR) exp_q.push_back(w);
    end else if (col < 1 || col > 80) begin
      m_err = sat(m_err);
    end else begin
      m_dr = sat(m_dr);
      if (!m_hdr) m_err = sat(m_err);
      exp_q.push_back(w);
    end
  endtask

  task automatic step();
    bit popped;
    @(negedge BUS_CLK);
    popped = RX_FIFO_READ;
    if (popped) begin
      if (src_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_src: got pop expected none (source empty)");
      end else begin
        consume(src_q.pop_front());
      end
      pop_cyc_q.push_back(cyc);
      npops++;
    end
    @(posedge BUS_CLK);
    #1;
    if (CNT_CLEAR) begin
      CNT_CLEAR = 0;
      chk("clr_dh", 32'(DH_CNT), 0);
    end
    if (popped && clr_on_pop) begin
      CNT_CLEAR  = 1;
      clr_on_pop = 0;
      model_zero();
    end
    ENABLE = en_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
    if (!ENABLE) m_hdr = 0;
    RX_FIFO_EMPTY = (src_q.size() == 0) ||
                    (gap_en && $urandom_range(0, 3) == 0);
    RX_FIFO_DATA  = (src_q.size() != 0) ? src_q[0] : $urandom();
    OUT_READY     = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    rdy_pct = 100; en_rand = 0; gap_en = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0",
               src_q.size() + exp_q.size());
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_dh"},  32'(DH_CNT),  32'(m_dh));
    chk({tag, "_dr"},  32'(DR_CNT),  32'(m_dr));
    chk({tag, "_sr"},  32'(SR_CNT),  32'(m_sr));
    chk({tag, "_err"}, 32'(ERR_CNT), 32'(m_err));
    chk({tag, "_idle"}, 32'(OUT_VALID), 0);
  endtask

  task automatic do_reset();
    BUS_RST_N = 0; ENABLE = 1; CNT_CLEAR = 0;
    RX_FIFO_EMPTY = 0; RX_FIFO_DATA = 32'h01E90000;
    src_q.delete(); exp_q.delete(); model_zero();
    @(negedge BUS_CLK);
    chk("rst_read",  32'(RX_FIFO_READ), 0);
    chk("rst_valid", 32'(OUT_VALID), 0);
    chk("rst_data",  OUT_DATA, 0);
    chk("rst_cnt",   32'({DH_CNT, DR_CNT} | {SR_CNT, ERR_CNT}), 0);
    @(posedge BUS_CLK);
    #1;
    BUS_RST_N = 1; RX_FIFO_EMPTY = 1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0]  idv, t;
    logic [15:0] lo;
    logic [6:0]  col;
    idv = ID; lo = 16'($urandom());
    col = 7'($urandom_range(1, 80));
    t = {col, 1'($urandom())};
    case ($urandom_range(0, 9))
      0: idv = 8'($urandom_range(2, 255));
      1, 2: t = 8'hE9;
      3: t = ($urandom_range(0, 1) != 0) ? 8'hEA : 8'hEC;
      4: t = 8'hEF;
      5: begin
        col = ($urandom_range(0, 1) != 0) ? 7'd0
              : 7'($urandom_range(81, 115));
        t = {col, 1'($urandom())};
      end
      default: ;
    endcase
    return {idv, t, lo};
  endfunction

  // Monitor: pops expectations whenever the DUT hands over a word.
  logic [31:0] hold_d;
  bit          hold_v = 0;
  initial forever begin
    @(negedge BUS_CLK);
    if (BUS_RST_N && dut.w_wr && int'(dut.w_occ) == DEPTH) begin
      checks++; errors++;
      $display("FAIL buf_overflow: got write expected no write (full)");
    end
    if (hold_v && OUT_VALID)
      chk("out_stable", OUT_DATA, hold_d);
    hold_v = OUT_VALID && !OUT_READY && BUS_RST_N;
    hold_d = OUT_DATA;
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got %0h expected none", OUT_DATA);
      end else begin
        chk("out_data", OUT_DATA, exp_q.pop_front());
      end
      acc_cyc_q.push_back(cyc);
    end
  end

  initial begin
    int ab, pb;
    logic [31:0] w;

    do_reset();

    // DH then data record, latency and counters.
    pb = pop_cyc_q.size(); ab = acc_cyc_q.size();
    src_q.push_back(32'h01E90000);
    src_q.push_back(32'h0102A5F0);
    drain(100);
    chk("t1_accepts", 32'(acc_cyc_q.size() - ab), 2);
    if (acc_cyc_q.size() > ab && pop_cyc_q.size() > pb)
      chk("t1_latency", 32'(acc_cyc_q[ab] - pop_cyc_q[pb]), 2);
    chk("t1_dh", 32'(DH_CNT), 1);
    chk("t1_dr", 32'(DR_CNT), 1);
    chk("t1_err", 32'(ERR_CNT), 0);
    check_counts("t1");

    // Wrong identifier and column 81.
    do_reset();
    ab = acc_cyc_q.size();
    src_q.push_back(32'h02E90000);
    src_q.push_back(32'h01A20000);
    drain(100);
    chk("t2_accepts", 32'(acc_cyc_q.size() - ab), 0);
    chk("t2_err", 32'(ERR_CNT), 2);
    chk("t2_dh", 32'(DH_CNT), 0);

    // Service record dropped, then forwarded.
    DROP_SR = 1;
    ab = acc_cyc_q.size();
    src_q.push_back(32'h01EF0123);
    drain(100);
    chk("t3_drop_acc", 32'(acc_cyc_q.size() - ab), 0);
    chk("t3_sr", 32'(SR_CNT), 1);
    DROP_SR = 0;
    src_q.push_back(32'h01EF0123);
    drain(100);
    chk("t3_fwd_acc", 32'(acc_cyc_q.size() - ab), 1);
    chk("t3_sr2", 32'(SR_CNT), 2);

    // Orphan data record.
    do_reset();
    ab = acc_cyc_q.size();
    src_q.push_back(32'h01040010);
    drain(100);
    chk("t4_accepts", 32'(acc_cyc_q.size() - ab), 1);
    chk("t4_dr", 32'(DR_CNT), 1);
    chk("t4_err", 32'(ERR_CNT), 1);

    // Backpressure: only OUT_DEPTH pops, then full-rate release.
    do_reset();
    rdy_pct = 0; gap_en = 0; en_rand = 0;
    src_q.push_back(32'h01E90000);
    for (int i = 1; i < 100; i++) begin
      w = {ID, 7'($urandom_range(1, 80)), 17'($urandom())};
      src_q.push_back(w);
    end
    ab = acc_cyc_q.size(); npops = 0;
    repeat (20) step();
    chk("t5_pops", 32'(npops), DEPTH);
    @(negedge BUS_CLK);
    chk("t5_stall", 32'(RX_FIFO_READ), 0);
    drain(500);
    chk("t5_accepts", 32'(acc_cyc_q.size() - ab), 100);
    if (acc_cyc_q.size() >= ab + 100)
      chk("t5_rate", 32'(acc_cyc_q[ab+99] - acc_cyc_q[ab]), 99);
    check_counts("t5");

    // Saturation, then clear coinciding with a DH.
    do_reset();
    for (int i = 0; i < 65536; i++)
      src_q.push_back({ID, 8'hE9, 16'(i)});
    drain(70000);
    chk("t6_sat", 32'(DH_CNT), 32'hFFFF);
    check_counts("t6");
    clr_on_pop = 1;
    src_q.push_back(32'h01E90000);
    drain(100);
    chk("t6_clr", 32'(DH_CNT), 0);
    check_counts("t6c");

    // Randomized phases with gaps, backpressure and ENABLE toggling.
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int n;
      DROP_SR = 1'($urandom_range(0, 1));
      for (int i = 0; i < 300; i++)
        src_q.push_back(rand_word());
      gap_en = 1; en_rand = 1;
      rdy_pct = $urandom_range(20, 100);
      n = 0;
      while (src_q.size() != 0 && n < 5000) begin
        step();
        n++;
        if (ph == 2 && n == 50) do_reset();
      end
      drain(2000);
      check_counts("rnd");
      if (ph == 3) begin
        CNT_CLEAR = 1;
        model_zero();
        step();
        check_counts("rnd_clr");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
